// File: rtl/q100_pkg.sv
// Shared types for the q100 hazard controller: FSM states and forwarding selects.
package q100_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/q100_config.svh
// q100 core-wide configuration: opcode field width and RV32I major opcodes.
`ifndef Q100_CONFIG_SVH
`define Q100_CONFIG_SVH

`define LEN_OPCODE              7
`define OPCODE_LOAD             7'b0000011
`define OPCODE_OP_IMM           7'b0010011
`define OPCODE_STORE            7'b0100011
`define OPCODE_OP               7'b0110011
`define OPCODE_BRANCH           7'b1100011
`define OPCODE_ECALL_EBREAK_CSR 7'b1110011

`endif

// File: rtl/q100_hazard_cmp.sv
// Forwarding source select for one ID source register; EX/MEM beats MEM/WB, x0 never forwards.
module q100_hazard_cmp
    import q100_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] ex_rd,
    input  logic       ex_wb,
    input  logic [4:0] mem_rd,
    input  logic       mem_wb,
    output fwd_sel_e   sel
);

    always_comb begin
        if (ex_wb && (ex_rd != 5'd0) && (ex_rd == rs))
            sel = FWD_EXMEM;
        else if (mem_wb && (mem_rd != 5'd0) && (mem_rd == rs))
            sel = FWD_MEMWB;
        else
            sel = FWD_NONE;
    end

endmodule

// File: rtl/q100_hazard_ctrl.sv
// Pipeline hazard controller beside ID: redirect flush, load-use bubble, SYSTEM/CSR drain,
// registered forwarding selects. Optional perf counters when HAZARD_PERF_EN is defined.
//
// state | meaning
// RUN   | normal flow; detects load-use and SYSTEM/CSR ops in ID
// FLUSH | bubbles into EX after a taken redirect, cnt counts remaining keep cycles
// DRAIN | SYSTEM/CSR op held in ID while older instrs retire, cnt counts remaining stalls
`include "q100_config.svh"

module q100_hazard_ctrl
    import q100_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 3
`ifdef HAZARD_PERF_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid_i,
    input  logic [`LEN_OPCODE-1:0] id_opcode_i,
    input  logic [4:0]             id_rs1_i,
    input  logic [4:0]             id_rs2_i,
    input  logic [4:0]             ex_rd_i,
    input  logic                   ex_wb_i,
    input  logic                   ex_mem_i,
    input  logic                   ex_load_i,
    input  logic [4:0]             mem_rd_i,
    input  logic                   mem_wb_i,
    input  logic                   redirect_i,
    output logic                   if_stall_o,
    output logic                   id_keep_o,
    output logic                   ex_flush_o,
    output logic [1:0]             fwd_rs1_sel_o,
    output logic [1:0]             fwd_rs2_sel_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]      perf_stall_cnt_o,
    output logic [PERF_W-1:0]      perf_flush_cnt_o
`endif
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    hz_state_e  state;
    logic [2:0] cnt;
    logic       rs2_used;
    logic       load_use;
    logic       serialise;
    fwd_sel_e   sel_rs1;
    fwd_sel_e   sel_rs2;

    assign rs2_used  = (id_opcode_i == `OPCODE_STORE) || (id_opcode_i == `OPCODE_BRANCH) ||
                       (id_opcode_i == `OPCODE_OP);
    assign load_use  = id_valid_i && ex_load_i && ex_mem_i && ex_wb_i && (ex_rd_i != 5'd0) &&
                       ((ex_rd_i == id_rs1_i) || (rs2_used && (ex_rd_i == id_rs2_i)));
    assign serialise = id_valid_i && (id_opcode_i == `OPCODE_ECALL_EBREAK_CSR);

    q100_hazard_cmp u_cmp_rs1 (
        .rs     (id_rs1_i),
        .ex_rd  (ex_rd_i),
        .ex_wb  (ex_wb_i),
        .mem_rd (mem_rd_i),
        .mem_wb (mem_wb_i),
        .sel    (sel_rs1)
    );

    q100_hazard_cmp u_cmp_rs2 (
        .rs     (id_rs2_i),
        .ex_rd  (ex_rd_i),
        .ex_wb  (ex_wb_i),
        .mem_rd (mem_rd_i),
        .mem_wb (mem_wb_i),
        .sel    (sel_rs2)
    );

    // A redirect overrides everything: the ID instruction is wrong-path.
    always_comb begin
        if_stall_o = 1'b0;
        id_keep_o  = 1'b0;
        ex_flush_o = 1'b0;
        if (redirect_i) begin
            ex_flush_o = 1'b1;
            id_keep_o  = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (load_use || serialise) begin
                        if_stall_o = 1'b1;
                        id_keep_o  = 1'b1;
                    end
                end
                FLUSH: id_keep_o = (cnt != 3'd0);
                DRAIN: begin
                    if_stall_o = (cnt != 3'd0);
                    id_keep_o  = (cnt != 3'd0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            cnt           <= 3'd0;
            fwd_rs1_sel_o <= FWD_NONE;
            fwd_rs2_sel_o <= FWD_NONE;
        end else begin
            fwd_rs1_sel_o <= id_keep_o ? FWD_NONE : sel_rs1;
            fwd_rs2_sel_o <= id_keep_o ? FWD_NONE : sel_rs2;
            if (redirect_i) begin
                state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                cnt   <= FLUSH_INIT;
            end else begin
                case (state)
                    RUN: begin
                        if (!load_use && serialise) begin
                            state <= DRAIN;
                            cnt   <= DRAIN_INIT;
                        end
                    end
                    FLUSH, DRAIN: begin
                        if (cnt != 3'd0) cnt <= cnt - 3'd1;
                        else             state <= RUN;
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (if_stall_o && (perf_stall_cnt_o != {PERF_W{1'b1}}))
                perf_stall_cnt_o <= perf_stall_cnt_o + 1'b1;
            if (redirect_i && (perf_flush_cnt_o != {PERF_W{1'b1}}))
                perf_flush_cnt_o <= perf_flush_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_q100_hazard_ctrl.sv
// Directed bench for q100_hazard_ctrl (FLUSH_CYCLES=2, DRAIN_CYCLES=3); checks {stall,keep,flush} and fwd selects.
module tb_q100_hazard_ctrl;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid_i;
    logic [6:0] id_opcode_i;
    logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i;
    logic       ex_wb_i, ex_mem_i, ex_load_i, mem_wb_i, redirect_i;
    logic       if_stall_o, id_keep_o, ex_flush_o;
    logic [1:0] fwd_rs1_sel_o, fwd_rs2_sel_o;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [2:0] ctl;

    assign ctl = {if_stall_o, id_keep_o, ex_flush_o};

    always #5 clk = ~clk;

    q100_hazard_ctrl #(.FLUSH_CYCLES(2), .DRAIN_CYCLES(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid_i    (id_valid_i),
        .id_opcode_i   (id_opcode_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .ex_rd_i       (ex_rd_i),
        .ex_wb_i       (ex_wb_i),
        .ex_mem_i      (ex_mem_i),
        .ex_load_i     (ex_load_i),
        .mem_rd_i      (mem_rd_i),
        .mem_wb_i      (mem_wb_i),
        .redirect_i    (redirect_i),
        .if_stall_o    (if_stall_o),
        .id_keep_o     (id_keep_o),
        .ex_flush_o    (ex_flush_o),
        .fwd_rs1_sel_o (fwd_rs1_sel_o),
        .fwd_rs2_sel_o (fwd_rs2_sel_o)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
    );

    task automatic idle();
        id_valid_i = 1'b0; id_opcode_i = OP_OPIMM; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
        ex_rd_i = 5'd0; ex_wb_i = 1'b0; ex_mem_i = 1'b0; ex_load_i = 1'b0;
        mem_rd_i = 5'd0; mem_wb_i = 1'b0; redirect_i = 1'b0;
    endtask

    task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2);
        id_valid_i = 1'b1; id_opcode_i = op; id_rs1_i = rs1; id_rs2_i = rs2;
    endtask

    task automatic set_ex_load(input logic [4:0] rd);
        ex_rd_i = rd; ex_wb_i = 1'b1; ex_mem_i = 1'b1; ex_load_i = 1'b1;
    endtask

    // advance to 1 time unit after the next rising edge, then let combinational outputs settle
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #12;
        total++; if (ctl !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", ctl); end
        total++; if ({fwd_rs1_sel_o, fwd_rs2_sel_o} !== 4'b0000) begin bad++; $display("FAIL reset_fwd got=%b want=0000", {fwd_rs1_sel_o, fwd_rs2_sel_o}); end
`ifdef HAZARD_PERF_EN
        total++; if ({perf_stall_cnt_o, perf_flush_cnt_o} !== 64'd0) begin bad++; $display("FAIL reset_perf got=%0h want=0", {perf_stall_cnt_o, perf_flush_cnt_o}); end
`endif
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        idle();
        set_ex_load(5'd5); set_id(OP_OP, 5'd5, 5'd1);
        #1;
        total++; if (ctl !== 3'b110) begin bad++; $display("FAIL lu_detect got=%b want=110", ctl); end
        tick();
        idle();
        mem_rd_i = 5'd5; mem_wb_i = 1'b1; set_id(OP_OP, 5'd5, 5'd1);
        #1;
        total++; if (ctl !== 3'b000) begin bad++; $display("FAIL lu_one_bubble got=%b want=000", ctl); end
        total++; if (fwd_rs1_sel_o !== 2'b00) begin bad++; $display("FAIL lu_fwd_forced got=%b want=00", fwd_rs1_sel_o); end
        tick();
        total++; if ({fwd_rs1_sel_o, fwd_rs2_sel_o} !== 4'b1000) begin bad++; $display("FAIL lu_fwd_memwb got=%b want=1000", {fwd_rs1_sel_o, fwd_rs2_sel_o}); end
        // rs2 only counts for opcodes that read it
        idle();
        set_ex_load(5'd5); set_id(OP_OPIMM, 5'd2, 5'd5);
        #1;
        total++; if (ctl !== 3'b000) begin bad++; $display("FAIL lu_opimm_rs2 got=%b want=000", ctl); end
        set_id(OP_STORE, 5'd2, 5'd5);
        #1;
        total++; if (ctl !== 3'b110) begin bad++; $display("FAIL lu_store_rs2 got=%b want=110", ctl); end
        set_ex_load(5'd0); set_id(OP_OP, 5'd0, 5'd0);
        #1;
        total++; if (ctl !== 3'b000) begin bad++; $display("FAIL lu_x0 got=%b want=000", ctl); end
        tick();
    endtask

    task automatic test_forward();
        idle();
        ex_rd_i = 5'd3; ex_wb_i = 1'b1; mem_rd_i = 5'd3; mem_wb_i = 1'b1;
        set_id(OP_OP, 5'd3, 5'd3);
        tick();
        total++; if ({fwd_rs1_sel_o, fwd_rs2_sel_o} !== 4'b0101) begin bad++; $display("FAIL fwd_exmem_wins got=%b want=0101", {fwd_rs1_sel_o, fwd_rs2_sel_o}); end
        ex_rd_i = 5'd0; ex_wb_i = 1'b1; mem_rd_i = 5'd4; mem_wb_i = 1'b1;
        set_id(OP_OP, 5'd0, 5'd4);
        tick();
        total++; if ({fwd_rs1_sel_o, fwd_rs2_sel_o} !== 4'b0010) begin bad++; $display("FAIL fwd_x0_memwb got=%b want=0010", {fwd_rs1_sel_o, fwd_rs2_sel_o}); end
        mem_wb_i = 1'b0;
        tick();
        total++; if ({fwd_rs1_sel_o, fwd_rs2_sel_o} !== 4'b0000) begin bad++; $display("FAIL fwd_no_wb got=%b want=0000", {fwd_rs1_sel_o, fwd_rs2_sel_o}); end
    endtask

    task automatic test_redirect();
        logic [2:0] exp_ctl [4] = '{3'b011, 3'b010, 3'b000, 3'b110};
        idle();
        set_ex_load(5'd7); set_id(OP_OP, 5'd7, 5'd7);
        for (int c = 0; c < 4; c++) begin
            redirect_i = (c == 0);
            #1;
            total++; if (ctl !== exp_ctl[c]) begin bad++; $display("FAIL redirect_c%0d got=%b want=%b", c, ctl, exp_ctl[c]); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_drain();
        logic [2:0] exp_ctl [5] = '{3'b110, 3'b110, 3'b110, 3'b000, 3'b000};
        idle();
        for (int c = 0; c < 5; c++) begin
            if (c < 4) set_id(OP_SYSTEM, 5'd1, 5'd0);
            else       set_id(OP_OP, 5'd1, 5'd2);
            #1;
            total++; if (ctl !== exp_ctl[c]) begin bad++; $display("FAIL drain_c%0d got=%b want=%b", c, ctl, exp_ctl[c]); end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_drain_redirect();
        logic [2:0] exp_ctl [6] = '{3'b110, 3'b110, 3'b011, 3'b010, 3'b000, 3'b000};
        idle();
        for (int c = 0; c < 6; c++) begin
            if (c < 5) set_id(OP_SYSTEM, 5'd1, 5'd0);
            else       idle();
            redirect_i = (c == 2);
            #1;
            total++; if (ctl !== exp_ctl[c]) begin bad++; $display("FAIL drain_redir_c%0d got=%b want=%b", c, ctl, exp_ctl[c]); end
            tick();
        end
    endtask

    task automatic test_reset_mid_flush();
        idle();
        ex_rd_i = 5'd3; ex_wb_i = 1'b1; set_id(OP_OP, 5'd3, 5'd0);
        tick();
        total++; if (fwd_rs1_sel_o !== 2'b01) begin bad++; $display("FAIL rst_pre_fwd got=%b want=01", fwd_rs1_sel_o); end
        redirect_i = 1'b1;
        tick();
        redirect_i = 1'b0;
        #1;
        total++; if (ctl !== 3'b010) begin bad++; $display("FAIL rst_in_flush got=%b want=010", ctl); end
        rst_n = 1'b0;
        #1;
        total++; if ({ctl, fwd_rs1_sel_o, fwd_rs2_sel_o} !== 7'b0) begin bad++; $display("FAIL rst_async got=%b want=0000000", {ctl, fwd_rs1_sel_o, fwd_rs2_sel_o}); end
`ifdef HAZARD_PERF_EN
        total++; if ({perf_stall_cnt_o, perf_flush_cnt_o} !== 64'd0) begin bad++; $display("FAIL rst_perf got=%0h want=0", {perf_stall_cnt_o, perf_flush_cnt_o}); end
`endif
        #3;
        rst_n = 1'b1;
        idle();
        tick();
        total++; if (ctl !== 3'b000) begin bad++; $display("FAIL rst_no_residual got=%b want=000", ctl); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_redirect();
        test_drain();
        test_drain_redirect();
        test_reset_mid_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
